// File: rtl/xup_tff_toggle_arbiter.sv
// Four-requester round-robin arbiter that lets the granted requester XOR its mask into a shared T-FF vector.
// Define XUP_TFF_ARB_LOCK_EN to let a requester hold ownership via lock for back-to-back applications.
module xup_tff_toggle_arbiter #(
  parameter int SIZE  = 8,
  parameter int DELAY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [3:0]        req,
  input  logic [4*SIZE-1:0] t_in,
  input  logic [3:0]        lock,
  output logic [3:0]        gnt,
  output logic              busy,
  output logic [SIZE-1:0]   q
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [3:0]      gnt_n;
  logic [SIZE-1:0] q_n;
  logic [1:0]      pick;
  logic [1:0]      cand;
  logic            found;
  logic            hold;
  logic [SIZE-1:0] mask [4];

  // Registered updates are zero-delay in this implementation; DELAY is kept for interface compatibility.
  logic [31:0] unused_delay;
  assign unused_delay = 32'(DELAY);

  for (genvar g = 0; g < 4; g++) begin : g_mask
    assign mask[g] = t_in[g*SIZE +: SIZE];
  end

`ifdef XUP_TFF_ARB_LOCK_EN
  assign hold = lock[ptr] & req[ptr];
`else
  logic [3:0] unused_lock;
  assign unused_lock = lock;
  assign hold = 1'b0;
`endif

  // Round-robin search starting just after the last granted index, wrapping back to it last.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // In GRANT the pointer already names the owner, so it doubles as the application index.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    q_n     = q;
    if (en) begin
      if (clr) begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        q_n     = '0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              state_n = GRANT;
              ptr_n   = pick;
              gnt_n   = 4'b0001 << pick;
            end else begin
              gnt_n   = 4'b0000;
            end
          end
          GRANT: begin
            q_n = q ^ mask[ptr];
            if (!hold) begin
              state_n = IDLE;
              gnt_n   = 4'b0000;
            end
          end
          default: begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        endcase
      end
    end
  end

  // ptr resets to 3 so requester 0 is the first to win after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 2'd3;
      gnt   <= 4'b0000;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      q     <= q_n;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_xup_tff_toggle_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an ownership-level model (honours XUP_TFF_ARB_LOCK_EN).
module tb_xup_tff_toggle_arbiter;

  localparam int SIZE = 8;

  logic              clk;
  logic              reset;
  logic              en;
  logic              clr;
  logic [3:0]        req;
  logic [4*SIZE-1:0] t_in;
  logic [3:0]        lock;
  logic [3:0]        gnt;
  logic              busy;
  logic [SIZE-1:0]   q;

  int total;
  int bad;

  // Model: who owns the shared register (-1 = nobody), last winner, and the register value.
  int              m_owner;
  int              m_last;
  logic [SIZE-1:0] m_q;

  xup_tff_toggle_arbiter #(.SIZE(SIZE), .DELAY(3)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (clr),
    .req  (req),
    .t_in (t_in),
    .lock (lock),
    .gnt  (gnt),
    .busy (busy),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SIZE-1:0] maskOf(input int idx);
    logic [4*SIZE-1:0] all;
    all = t_in;
    return all[idx*SIZE +: SIZE];
  endfunction

  task automatic modelReset();
    m_owner = -1;
    m_last  = 3;
    m_q     = '0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic modelEdge();
    bit keep;
    if (!reset) begin
      modelReset();
    end else if (en) begin
      if (clr) begin
        m_q     = '0;
        m_owner = -1;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_owner < 0 && req[c]) begin
            m_owner = c;
            m_last  = c;
          end
        end
      end else begin
        m_q  = m_q ^ maskOf(m_owner);
        keep = 1'b0;
`ifdef XUP_TFF_ARB_LOCK_EN
        keep = lock[m_owner] && req[m_owner];
`endif
        if (!keep) m_owner = -1;
      end
    end
  endtask

  task automatic checkOutput(input string name);
    logic [3:0] eg;
    logic       eb;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    eb = (m_owner >= 0);
    total++;
    if (gnt !== eg || busy !== eb || q !== m_q) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got gnt=%b busy=%b q=%h, want gnt=%b busy=%b q=%h",
               name, $time, gnt, busy, q, eg, eb, m_q);
    end
  endtask

  task automatic checkLit(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s @%0t: got %h, want %h", name, $time, actual, expected);
    end
  endtask

  // Called just after a falling edge: inputs are already set for the coming rising edge.
  task automatic applyStimulus(input string name);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(name);
  endtask

  task automatic setMask(input int idx, input logic [SIZE-1:0] m);
    t_in[idx*SIZE +: SIZE] = m;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    checkOutput("reset");
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    req   = 4'b0000;
    t_in  = '0;
    lock  = 4'b0000;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkLit("reset_gnt", 32'(gnt), 32'h0);
    checkLit("reset_busy", 32'(busy), 32'h0);
    checkLit("reset_q", 32'(q), 32'h0);
    reset = 1'b1;

    // Single request from requester 0.
    req = 4'b0001;
    setMask(0, 8'h0F);
    applyStimulus("single_grant");
    checkLit("single_gnt", 32'(gnt), 32'h1);
    checkLit("single_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    applyStimulus("single_apply");
    checkLit("single_q", 32'(q), 32'h0F);
    checkLit("single_busy_low", 32'(busy), 32'h0);

    // All four requesting: strict rotation, one grant every other cycle.
    doReset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) setMask(i, 8'h01);
    begin
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        applyStimulus("rr_grant");
        checkLit("rr_gnt", 32'(gnt), 32'(seq[i]));
        applyStimulus("rr_apply");
        checkLit("rr_q", 32'(q), (i % 2 == 0) ? 32'h01 : 32'h00);
      end
    end

    // Clear during GRANT discards the application but keeps the pointer.
    doReset();
    req = 4'b0001;
    setMask(0, 8'hAA);
    applyStimulus("clr_g0");
    req = 4'b0000;
    applyStimulus("clr_a0");
    checkLit("clr_q_aa", 32'(q), 32'hAA);
    req = 4'b0010;
    setMask(1, 8'h55);
    applyStimulus("clr_g1");
    checkLit("clr_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    clr = 1'b1;
    applyStimulus("clr_edge");
    checkLit("clr_q0", 32'(q), 32'h00);
    checkLit("clr_gnt0", 32'(gnt), 32'h0);
    clr = 1'b0;
    req = 4'b0110;
    setMask(2, 8'h0F);
    applyStimulus("clr_next");
    checkLit("clr_ptr_kept", 32'(gnt), 32'h4);

    // Enable dropped for three cycles mid-GRANT.
    req = 4'b0000;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("en_hold");
      checkLit("en_gnt_held", 32'(gnt), 32'h4);
      checkLit("en_q_held", 32'(q), 32'h00);
    end
    en = 1'b1;
    applyStimulus("en_resume");
    checkLit("en_q_applied", 32'(q), 32'h0F);
    checkLit("en_gnt_done", 32'(gnt), 32'h0);

    // Asynchronous reset between edges while in GRANT.
    req = 4'b1000;
    setMask(3, 8'hFF);
    applyStimulus("ar_grant");
    checkLit("ar_gnt", 32'(gnt), 32'h8);
    #2;
    reset = 1'b0;
    #1;
    checkLit("ar_q", 32'(q), 32'h00);
    checkLit("ar_gnt0", 32'(gnt), 32'h0);
    checkLit("ar_busy0", 32'(busy), 32'h0);
    modelReset();
    @(negedge clk);
    checkOutput("ar_after");
    reset = 1'b1;

`ifdef XUP_TFF_ARB_LOCK_EN
    // Locked owner gets one application per cycle.
    req  = 4'b0011;
    lock = 4'b0010;
    for (int i = 0; i < 4; i++) setMask(i, 8'h01);
    applyStimulus("lk_g0");
    checkLit("lk_first", 32'(gnt), 32'h1);
    applyStimulus("lk_a0");
    applyStimulus("lk_g1");
    checkLit("lk_gnt1", 32'(gnt), 32'h2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("lk_apply");
      checkLit("lk_gnt_held", 32'(gnt), 32'h2);
      checkLit("lk_q", 32'(q), (i % 2 == 0) ? 32'h00 : 32'h01);
    end
    lock = 4'b0000;
    req  = 4'b0000;
    applyStimulus("lk_release");
    checkLit("lk_gnt_rel", 32'(gnt), 32'h0);
`else
    // lock is ignored: requesters 0 and 1 alternate with idle cycles between.
    req  = 4'b0011;
    lock = 4'b0010;
    for (int i = 0; i < 4; i++) setMask(i, 8'h01);
    begin
      logic [3:0] seq [4];
      seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000};
      for (int i = 0; i < 4; i++) begin
        applyStimulus("nl_step");
        checkLit("nl_gnt", 32'(gnt), 32'(seq[i]));
      end
    end
    lock = 4'b0000;
    req  = 4'b0000;
`endif

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 800; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      req   = 4'($urandom);
      lock  = 4'($urandom);
      t_in  = $urandom;
      reset = ($urandom_range(0, 99) != 0);
      applyStimulus("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
